// File: rtl/bsg_cache_sbuf_arb.sv
// Store-buffer / read arbiter for the cache data SRAM.
// Reads win by default; the buffer head is forced through when the queue is full,
// when reads have starved it too long, or while a flush drains the queue.
// Optional feature macro: BSG_CACHE_SBUF_ARB_STARVE_GUARD_EN enables the starve counter.
module bsg_cache_sbuf_arb #(
  parameter int unsigned data_width_p = 16,
  parameter int unsigned addr_width_p = 8,
  parameter int unsigned max_starve_p = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    sbuf_v_i,
  input  logic [addr_width_p-1:0] sbuf_addr_i,
  input  logic [data_width_p-1:0] sbuf_data_i,
  input  logic                    sbuf_full_i,
  output logic                    sbuf_yumi_o,
  input  logic                    rd_v_i,
  input  logic [addr_width_p-1:0] rd_addr_i,
  output logic                    rd_ready_o,
  input  logic                    flush_i,
  output logic                    flush_done_o,
  output logic                    mem_v_o,
  output logic                    mem_w_o,
  output logic [addr_width_p-1:0] mem_addr_o,
  output logic [data_width_p-1:0] mem_data_o
);

  typedef enum logic {
    StIdle,
    StFlush
  } state_e;

  state_e r_state;
  logic   w_wr_g;
  logic   w_rd_g;
  logic   w_starved;

`ifdef BSG_CACHE_SBUF_ARB_STARVE_GUARD_EN
  localparam int unsigned StarveW = $clog2(max_starve_p + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(max_starve_p);

  logic [StarveW-1:0] r_starve;

  assign w_starved = (r_starve == StarveMax);

  // Count consecutive read wins over a waiting head entry; saturates at the limit.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_starve <= '0;
    end else if (w_wr_g || !sbuf_v_i) begin
      r_starve <= '0;
    end else if (w_rd_g && !w_starved) begin
      r_starve <= r_starve + 1'b1;
    end
  end
`else
  // Without the guard a write only wins on an idle read port or a full queue.
  assign w_starved = 1'b0;
`endif

  // Drain sequencer: leave FLUSH as soon as the queue reports empty.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= StIdle;
    end else begin
      unique case (r_state)
        StIdle:  if (flush_i) r_state <= StFlush;
        StFlush: if (!sbuf_v_i) r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  // Grant decode; in FLUSH the read port is locked out until the queue drains.
  always_comb begin
    w_wr_g       = 1'b0;
    w_rd_g       = 1'b0;
    flush_done_o = 1'b0;
    unique case (r_state)
      StFlush: begin
        w_wr_g       = sbuf_v_i;
        flush_done_o = ~sbuf_v_i;
      end
      default: begin
        w_wr_g = sbuf_v_i & (~rd_v_i | sbuf_full_i | w_starved);
        w_rd_g = rd_v_i & ~w_wr_g;
      end
    endcase
  end

  // SRAM port: single access per cycle, write data always taken from the head.
  always_comb begin
    sbuf_yumi_o = w_wr_g;
    rd_ready_o  = w_rd_g;
    mem_v_o     = w_wr_g | w_rd_g;
    mem_w_o     = w_wr_g;
    mem_addr_o  = w_wr_g ? sbuf_addr_i : rd_addr_i;
    mem_data_o  = sbuf_data_i;
  end

endmodule

// File: tb/tb_bsg_cache_sbuf_arb.sv
// Self-checking bench for bsg_cache_sbuf_arb: vector table, hand sequences for
// starvation / flush / reset corners, then random traffic against a reference model.
module tb_bsg_cache_sbuf_arb;

  localparam int unsigned DW        = 16;
  localparam int unsigned AW        = 8;
  localparam int          MaxStarve = 4;
`ifdef BSG_CACHE_SBUF_ARB_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sbuf_v = 1'b0;
  logic [AW-1:0] sbuf_addr = '0;
  logic [DW-1:0] sbuf_data = '0;
  logic          sbuf_full = 1'b0;
  logic          sbuf_yumi;
  logic          rd_v = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_ready;
  logic          flush = 1'b0;
  logic          flush_done;
  logic          mem_v;
  logic          mem_w;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;

  int errors = 0;
  int checks = 0;

  // Reference model state: draining flag and count of consecutive starved cycles.
  bit m_flush  = 1'b0;
  int m_starve = 0;

  always #5 clk = ~clk;

  bsg_cache_sbuf_arb #(
    .data_width_p(DW),
    .addr_width_p(AW),
    .max_starve_p(MaxStarve)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .sbuf_v_i    (sbuf_v),
    .sbuf_addr_i (sbuf_addr),
    .sbuf_data_i (sbuf_data),
    .sbuf_full_i (sbuf_full),
    .sbuf_yumi_o (sbuf_yumi),
    .rd_v_i      (rd_v),
    .rd_addr_i   (rd_addr),
    .rd_ready_o  (rd_ready),
    .flush_i     (flush),
    .flush_done_o(flush_done),
    .mem_v_o     (mem_v),
    .mem_w_o     (mem_w),
    .mem_addr_o  (mem_addr),
    .mem_data_o  (mem_data)
  );

  // {yumi, rd_ready, mem_v, mem_w, flush_done, mem_addr, mem_data}
  logic [28:0] w_out;
  assign w_out = {sbuf_yumi, rd_ready, mem_v, mem_w, flush_done, mem_addr, mem_data};

  function automatic logic [28:0] pack(input logic y, input logic r, input logic v,
                                       input logic w, input logic d,
                                       input logic [AW-1:0] a, input logic [DW-1:0] dat);
    return {y, r, v, w, d, a, dat};
  endfunction

  // Outputs the rules predict for the current inputs and model state.
  function automatic logic [28:0] model_out();
    logic wr, rd, done;
    if (m_flush) begin
      wr   = sbuf_v;
      rd   = 1'b0;
      done = !sbuf_v;
    end else begin
      wr   = sbuf_v && (!rd_v || sbuf_full || (Guard && m_starve >= MaxStarve));
      rd   = rd_v && !wr;
      done = 1'b0;
    end
    return pack(wr, rd, wr || rd, wr, done, wr ? sbuf_addr : rd_addr, sbuf_data);
  endfunction

  task automatic chk(input string name, input logic [28:0] act, input logic [28:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (yumi,rd,mv,mw,done,addr,data)", name, act, exp);
    end
  endtask

  task automatic apply(input logic sv, input logic full, input logic rv, input logic fl,
                       input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                       input logic [AW-1:0] ra);
    sbuf_v    = sv;
    sbuf_full = full;
    rd_v      = rv;
    flush     = fl;
    sbuf_addr = sa;
    sbuf_data = sd;
    rd_addr   = ra;
    #4;
  endtask

  // Advance one clock, moving the model alongside the DUT.
  task automatic tick();
    logic [28:0] o;
    bit nf;
    int ns;
    o  = model_out();
    nf = m_flush;
    ns = m_starve;
    if (m_flush) begin
      if (!sbuf_v) nf = 1'b0;
    end else if (flush) begin
      nf = 1'b1;
    end
    if (Guard) begin
      if (o[28] || !sbuf_v) ns = 0;
      else if (o[27]) ns = (m_starve + 1 > MaxStarve) ? MaxStarve : m_starve + 1;
    end
    @(posedge clk);
    if (!reset_n) begin
      m_flush  = 1'b0;
      m_starve = 0;
    end else begin
      m_flush  = nf;
      m_starve = ns;
    end
    #1;
  endtask

  // Continuous reads against a non-full head; expects starve counter to start at zero.
  task automatic starve_run(input int n, input string tag);
    logic ew;
    for (int i = 0; i < n; i++) begin
      apply(1'b1, 1'b0, 1'b1, 1'b0, 8'h12, 16'hA5A5, 8'h34);
      ew = Guard && (i % 5 == 4);
      chk($sformatf("%s_c%0d", tag, i), w_out,
          pack(ew, !ew, 1'b1, ew, 1'b0, ew ? 8'h12 : 8'h34, 16'hA5A5));
      tick();
    end
  endtask

  typedef struct {
    logic          sv;
    logic          full;
    logic          rv;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    logic [AW-1:0] ra;
    logic [28:0]   exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    // Vector table, applied from IDLE after reset; read wins never reach the starve limit.
    vecs[0] = '{1, 0, 0, 8'h55, 16'hBEEF, 8'h34, pack(1, 0, 1, 1, 0, 8'h55, 16'hBEEF)};
    vecs[1] = '{1, 1, 1, 8'h12, 16'h1234, 8'h34, pack(1, 0, 1, 1, 0, 8'h12, 16'h1234)};
    vecs[2] = '{0, 0, 1, 8'h12, 16'h0F0F, 8'h34, pack(0, 1, 1, 0, 0, 8'h34, 16'h0F0F)};
    vecs[3] = '{0, 0, 0, 8'h12, 16'h00FF, 8'h77, pack(0, 0, 0, 0, 0, 8'h77, 16'h00FF)};
    vecs[4] = '{1, 0, 1, 8'hA0, 16'hCAFE, 8'hB0, pack(0, 1, 1, 0, 0, 8'hB0, 16'hCAFE)};
    vecs[5] = '{1, 1, 1, 8'hA1, 16'hD00D, 8'hB1, pack(1, 0, 1, 1, 0, 8'hA1, 16'hD00D)};
    vecs[6] = '{1, 0, 1, 8'hA2, 16'h1357, 8'hB2, pack(0, 1, 1, 0, 0, 8'hB2, 16'h1357)};
    vecs[7] = '{0, 0, 1, 8'hA3, 16'h2468, 8'hB3, pack(0, 1, 1, 0, 0, 8'hB3, 16'h2468)};

    // Outputs during power-on reset follow IDLE equations.
    #2;
    apply(1'b1, 1'b0, 1'b1, 1'b0, 8'h12, 16'h5555, 8'h34);
    chk("por_reset", w_out, pack(0, 1, 1, 0, 0, 8'h34, 16'h5555));
    apply(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].sv, vecs[i].full, vecs[i].rv, 1'b0, vecs[i].sa, vecs[i].sd, vecs[i].ra);
      chk($sformatf("vec%0d", i), w_out, vecs[i].exp);
      tick();
    end

    // Starvation: 14 cycles leaves a guarded counter saturated for the reset test.
    apply(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00);
    tick();
    starve_run(14, "starve");

    // Asynchronous reset mid-cycle while a forced write would otherwise be granted.
    apply(1'b1, 1'b0, 1'b1, 1'b0, 8'h12, 16'hA5A5, 8'h34);
    chk("pre_rst", w_out, model_out());
    reset_n  = 1'b0;
    m_flush  = 1'b0;
    m_starve = 0;
    #1;
    chk("rst_async", w_out, pack(0, 1, 1, 0, 0, 8'h34, 16'hA5A5));
    @(posedge clk);
    #1;
    apply(1'b0, 1'b0, 1'b1, 1'b1, 8'h12, 16'hA5A5, 8'h34);
    chk("rst_hold", w_out, pack(0, 1, 1, 0, 0, 8'h34, 16'hA5A5));
    @(posedge clk);
    #1;
    apply(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00);
    reset_n = 1'b1;
    tick();
    starve_run(5, "post_rst");

    // Flush with two queued entries; request cycle still arbitrates reads.
    apply(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 8'h00);
    tick();
    apply(1'b1, 1'b0, 1'b1, 1'b1, 8'h20, 16'h1111, 8'h40);
    chk("fl_req", w_out, pack(0, 1, 1, 0, 0, 8'h40, 16'h1111));
    tick();
    apply(1'b1, 1'b1, 1'b1, 1'b0, 8'h21, 16'h2222, 8'h41);
    chk("fl_w0", w_out, pack(1, 0, 1, 1, 0, 8'h21, 16'h2222));
    tick();
    apply(1'b1, 1'b0, 1'b1, 1'b0, 8'h22, 16'h3333, 8'h42);
    chk("fl_w1", w_out, pack(1, 0, 1, 1, 0, 8'h22, 16'h3333));
    tick();
    apply(1'b0, 1'b0, 1'b1, 1'b0, 8'h23, 16'h4444, 8'h43);
    chk("fl_done", w_out, pack(0, 0, 0, 0, 1, 8'h43, 16'h4444));
    tick();
    apply(1'b0, 1'b0, 1'b1, 1'b0, 8'h23, 16'h4444, 8'h43);
    chk("fl_idle", w_out, pack(0, 1, 1, 0, 0, 8'h43, 16'h4444));
    tick();

    // Flush of an empty queue completes on the first FLUSH cycle.
    apply(1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 16'h7777, 8'h02);
    chk("ef_req", w_out, pack(0, 0, 0, 0, 0, 8'h02, 16'h7777));
    tick();
    apply(1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 16'h7777, 8'h02);
    chk("ef_done", w_out, pack(0, 0, 0, 0, 1, 8'h02, 16'h7777));
    tick();
    apply(1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 16'h7777, 8'h02);
    chk("ef_idle", w_out, pack(0, 1, 1, 0, 0, 8'h02, 16'h7777));
    tick();

    // Reset during FLUSH with one pending entry aborts the drain.
    apply(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 16'h0000, 8'h00);
    tick();
    apply(1'b1, 1'b0, 1'b1, 1'b0, 8'h55, 16'hABCD, 8'h66);
    chk("rf_pend", w_out, pack(1, 0, 1, 1, 0, 8'h55, 16'hABCD));
    reset_n  = 1'b0;
    m_flush  = 1'b0;
    m_starve = 0;
    #1;
    chk("rf_rst", w_out, pack(0, 1, 1, 0, 0, 8'h66, 16'hABCD));
    sbuf_v = 1'b0;
    #1;
    chk("rf_nodone", w_out, pack(0, 1, 1, 0, 0, 8'h66, 16'hABCD));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    apply(1'b0, 1'b0, 1'b1, 1'b0, 8'h55, 16'hABCD, 8'h66);
    chk("rf_idle", w_out, pack(0, 1, 1, 0, 0, 8'h66, 16'hABCD));
    tick();

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic sv, fu, rv, fl;
      sv = ($urandom % 4) != 0;
      fu = sv && (($urandom % 4) == 0);
      rv = ($urandom % 4) != 0;
      fl = ($urandom % 16) == 0;
      apply(sv, fu, rv, fl, AW'($urandom), DW'($urandom), AW'($urandom));
      chk($sformatf("rand%0d", i), w_out, model_out());
      if (sbuf_yumi && rd_ready) begin
        chk($sformatf("rand_excl%0d", i), {28'd0, 1'b1}, 29'd0);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
